dual_port_register_file: RTL and testbench
==========================================

// Module: dual_port_register_file
// PURPOSE
//  8-entry register file with two write ports and two independent read ports.
//  Writes carry no address: they fill entries in order through an internal
//  circular write pointer. Reads select any entry by 3-bit index.
//  Sits in the FPU datapath, e.g. as the exponent store with REGISTER_WIDTH=9.
// PARAMETERS
//  REGISTER_WIDTH  32  bit width of each entry, write values and read results
//  (local) NUM_REGS = 8, SEL_WIDTH = 3; fixed, not overridable
// PORTS
//  clk           in   1     single clock; all state updates on rising edge
//  reset         in   1     synchronous, active-low reset (0 = reset on clk rise)
//  writeEnableA  in   1     write writeValueA this cycle
//  writeEnableB  in   1     write writeValueB this cycle
//  writeValueA   in   RW    data for write port A
//  writeValueB   in   RW    data for write port B
//  readSelectA   in   3     entry index for read port A
//  readSelectB   in   3     entry index for read port B
//  readResultA   out  RW    contents of entry readSelectA
//  readResultB   out  RW    contents of entry readSelectB
// BEHAVIOUR
//  - State: regs[0..7] (RW bits each), wptr (3 bits).
//  - Reset (reset==0 at clk rise): all regs <= 0, wptr <= 0; write enables are
//    ignored that cycle. Reset has priority over every write.
//  - Only A enabled: regs[wptr] <= writeValueA; wptr <= wptr+1.
//  - Only B enabled: regs[wptr] <= writeValueB; wptr <= wptr+1.
//  - Both enabled: regs[wptr] <= writeValueA; regs[wptr+1] <= writeValueB;
//    wptr <= wptr+2. Port A always takes the lower slot.
//  - Neither enabled: no state change.
//  - All pointer arithmetic is mod 8. Entry 7 wraps to entry 0 and the oldest
//    data is overwritten silently. There is no full/empty flag.
//  - Reads are combinational: readResultX = regs[readSelectX].
//    * Zero-latency response to a select change.
//    * No write-to-read bypass: a value written at edge N is visible just
//      after edge N.
//    * Both read ports may select the same entry.
//  - Output values: 0 for every select after a reset edge. Before the first
//    reset they are undefined (X in simulation).
//  - Reset asserted mid-stream clears the contents and the pointer in one
//    cycle. The next write lands in entry 0.
// STRUCTURE
//  - Shared package: NUM_REGS and SEL_WIDTH constants. A typedef for the
//    entry word is optional.
//  - One sub-module is natural: wptr_counter, a 3-bit mod-8 counter with
//    synchronous active-low clear and an increment of 0/1/2.
//  - Storage and read muxes live in the top module.
// TESTING
//  - Reset: reset=0 for 1 edge with both enables high, then reset=1 ->
//    all 8 entries read 0 on both ports; wptr=0.
//  - Single writes (RW=9): write A 0x0AA, then write B 0x0BB ->
//    sel0=0x0AA, sel1=0x0BB; sel1 and sel0 read swapped on A/B also correct.
//  - Dual write: both enabled, A=0x011, B=0x022 from wptr=2 ->
//    entry2=0x011, entry3=0x022; wptr=4.
//  - Wrap: 9 single A writes of 0x100+i (i=0..8) after reset ->
//    entry0=0x108, entry1..7=0x101..0x107. Dual write from wptr=7 ->
//    A lands in entry7, B in entry0.
//  - Reset mid-operation: after 5 writes, pulse reset low for 1 edge ->
//    all reads 0. The next write of 0x1FF lands in entry0 only.
//  - Read comb/no bypass: write 0x055 into entry k ->
//    sel=k reads the old value before the edge and 0x055 immediately after.

Source files
------------

// File: rtl/dual_port_register_file_pkg.sv
// Shared constants for the dual-port register file: entry count and read-select width.
package dual_port_register_file_pkg;
    localparam int NUM_REGS  = 8;
    localparam int SEL_WIDTH = 3;
endpackage

// File: rtl/dual_port_register_file_if.sv
// Write and read bus of the register file; master drives writes/selects, slave returns read data.
interface dual_port_register_file_if
    import dual_port_register_file_pkg::*;
#(
    parameter int REGISTER_WIDTH = 32
);
    logic                      writeEnableA;
    logic                      writeEnableB;
    logic [REGISTER_WIDTH-1:0] writeValueA;
    logic [REGISTER_WIDTH-1:0] writeValueB;
    logic [SEL_WIDTH-1:0]      readSelectA;
    logic [SEL_WIDTH-1:0]      readSelectB;
    logic [REGISTER_WIDTH-1:0] readResultA;
    logic [REGISTER_WIDTH-1:0] readResultB;

    modport master (
        output writeEnableA, writeEnableB, writeValueA, writeValueB,
        output readSelectA, readSelectB,
        input  readResultA, readResultB
    );

    modport slave (
        input  writeEnableA, writeEnableB, writeValueA, writeValueB,
        input  readSelectA, readSelectB,
        output readResultA, readResultB
    );
endinterface

// File: rtl/dual_port_register_file_wptr_counter.sv
// Mod-8 write pointer: advances by 0, 1 or 2 per cycle, synchronous active-low clear.
module dual_port_register_file_wptr_counter
    import dual_port_register_file_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [1:0]           inc_i,
    output logic [SEL_WIDTH-1:0] wptr_o
);
    logic [SEL_WIDTH-1:0] wptr_q;
    logic [SEL_WIDTH-1:0] wptr_d;

    // Natural overflow of the 3-bit sum gives the mod-8 wrap.
    always_comb begin
        wptr_d = wptr_q + SEL_WIDTH'(inc_i);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
        end
    end

    assign wptr_o = wptr_q;
endmodule

// File: rtl/dual_port_register_file.sv
// 8-entry register file: two address-less write ports filling a circular pointer,
// two independent combinational read ports.
module dual_port_register_file
    import dual_port_register_file_pkg::*;
#(
    parameter int REGISTER_WIDTH = 32
)(
    input  logic                      clk,
    input  logic                      reset,
    dual_port_register_file_if.slave  bus
);
    logic [REGISTER_WIDTH-1:0] regs_q [NUM_REGS];
    logic [REGISTER_WIDTH-1:0] regs_d [NUM_REGS];
    logic [SEL_WIDTH-1:0]      wptr;
    logic [SEL_WIDTH-1:0]      wptr_plus1;
    logic [1:0]                inc;

    assign inc        = {bus.writeEnableA & bus.writeEnableB,
                         bus.writeEnableA ^ bus.writeEnableB};
    assign wptr_plus1 = wptr + SEL_WIDTH'(1);

    dual_port_register_file_wptr_counter u_wptr (
        .clk    (clk),
        .reset  (reset),
        .inc_i  (inc),
        .wptr_o (wptr)
    );

    // Port A always takes the lower slot when both ports write together.
    always_comb begin
        regs_d = regs_q;
        if (bus.writeEnableA && bus.writeEnableB) begin
            regs_d[wptr]       = bus.writeValueA;
            regs_d[wptr_plus1] = bus.writeValueB;
        end else if (bus.writeEnableA) begin
            regs_d[wptr] = bus.writeValueA;
        end else if (bus.writeEnableB) begin
            regs_d[wptr] = bus.writeValueB;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign bus.readResultA = regs_q[bus.readSelectA];
    assign bus.readResultB = regs_q[bus.readSelectB];
endmodule

// File: tb/tb_dual_port_register_file.sv
// Scoreboard bench for dual_port_register_file with 9-bit entries and directed vectors.
module tb_dual_port_register_file;
    localparam int RW = 9;

    typedef struct {
        logic [RW-1:0] exp_a;
        logic [RW-1:0] exp_b;
        string         name;
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];
    event sample_ev;

    dual_port_register_file_if #(.REGISTER_WIDTH(RW)) bus ();

    dual_port_register_file #(.REGISTER_WIDTH(RW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: compares the live read ports against each queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_checks++;
                if (bus.readResultA !== e.exp_a || bus.readResultB !== e.exp_b) begin
                    n_fail++;
                    $display("FAIL %s: got A=%h B=%h, expected A=%h B=%h",
                             e.name, bus.readResultA, bus.readResultB, e.exp_a, e.exp_b);
                end
            end
        end
    end

    task automatic push_exp(input logic [RW-1:0] ea, input logic [RW-1:0] eb, input string nm);
        exp_t e;
        e.exp_a = ea;
        e.exp_b = eb;
        e.name  = nm;
        exp_q.push_back(e);
        ->sample_ev;
    endtask

    task automatic check(input int sa, input int sb, input logic [RW-1:0] ea,
                         input logic [RW-1:0] eb, input string nm);
        @(negedge clk);
        bus.readSelectA = 3'(sa);
        bus.readSelectB = 3'(sb);
        #1;
        push_exp(ea, eb, nm);
        #1;
    endtask

    task automatic wr(input logic ena, input logic enb, input logic [RW-1:0] va,
                      input logic [RW-1:0] vb);
        @(negedge clk);
        bus.writeEnableA = ena;
        bus.writeEnableB = enb;
        bus.writeValueA  = va;
        bus.writeValueB  = vb;
        @(posedge clk);
        #1;
        bus.writeEnableA = 1'b0;
        bus.writeEnableB = 1'b0;
    endtask

    task automatic do_reset(input logic en_both);
        @(negedge clk);
        reset            = 1'b0;
        bus.writeEnableA = en_both;
        bus.writeEnableB = en_both;
        bus.writeValueA  = 9'h1AA;
        bus.writeValueB  = 9'h1BB;
        @(posedge clk);
        #1;
        reset            = 1'b1;
        bus.writeEnableA = 1'b0;
        bus.writeEnableB = 1'b0;
    endtask

    task automatic check_all_zero(input string nm);
        for (int i = 0; i < 8; i++) begin
            check(i, 7 - i, '0, '0, nm);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks         = 0;
        n_fail           = 0;
        reset            = 1'b1;
        bus.writeEnableA = 1'b0;
        bus.writeEnableB = 1'b0;
        bus.writeValueA  = '0;
        bus.writeValueB  = '0;
        bus.readSelectA  = '0;
        bus.readSelectB  = '0;
        repeat (2) @(posedge clk);

        // Reset with both enables high: everything clears, writes ignored.
        do_reset(1'b1);
        check_all_zero("reset_clear");

        // Single writes from pointer 0.
        wr(1'b1, 1'b0, 9'h0AA, 9'h000);
        wr(1'b0, 1'b1, 9'h000, 9'h0BB);
        check(0, 1, 9'h0AA, 9'h0BB, "single_wr");
        check(1, 0, 9'h0BB, 9'h0AA, "single_wr_swapped");
        check(2, 2, 9'h000, 9'h000, "single_wr_untouched");

        // Dual write from pointer 2, then a single write confirms pointer 4.
        wr(1'b1, 1'b1, 9'h011, 9'h022);
        check(2, 3, 9'h011, 9'h022, "dual_wr");
        wr(1'b1, 1'b0, 9'h033, 9'h000);
        check(4, 4, 9'h033, 9'h033, "dual_wr_ptr4_same_sel");

        // Wrap: nine single writes after reset.
        do_reset(1'b0);
        for (int i = 0; i < 9; i++) wr(1'b1, 1'b0, 9'(9'h100 + i), 9'h000);
        check(0, 1, 9'h108, 9'h101, "wrap_e0_e1");
        for (int i = 2; i < 8; i++) check(i, i, 9'(9'h100 + i), 9'(9'h100 + i), "wrap_e2_e7");

        // Advance pointer to 7, then dual write straddles the wrap.
        for (int i = 0; i < 6; i++) wr(1'b0, 1'b1, 9'h000, 9'(9'h140 + i));
        wr(1'b1, 1'b1, 9'h0CC, 9'h0DD);
        check(7, 0, 9'h0CC, 9'h0DD, "dual_wrap_7_0");
        check(1, 6, 9'h140, 9'h145, "dual_wrap_neighbours");
        wr(1'b1, 1'b0, 9'h0EE, 9'h000);
        check(1, 2, 9'h0EE, 9'h141, "dual_wrap_ptr1");

        // Mid-stream reset.
        do_reset(1'b0);
        for (int i = 0; i < 5; i++) wr(1'b1, 1'b0, 9'(9'h010 + i), 9'h000);
        check(4, 0, 9'h014, 9'h010, "pre_mid_reset");
        do_reset(1'b0);
        check_all_zero("mid_reset_clear");
        wr(1'b1, 1'b0, 9'h1FF, 9'h000);
        check(0, 1, 9'h1FF, 9'h000, "post_reset_wr_e0");
        for (int i = 2; i < 8; i++) check(i, 1, 9'h000, 9'h000, "post_reset_others");

        // Combinational read, no bypass: entry 1 old before edge, new after.
        @(negedge clk);
        bus.readSelectA  = 3'd1;
        bus.readSelectB  = 3'd0;
        bus.writeEnableA = 1'b1;
        bus.writeValueA  = 9'h055;
        #1;
        push_exp(9'h000, 9'h1FF, "no_bypass_before_edge");
        @(posedge clk);
        #1;
        push_exp(9'h055, 9'h1FF, "visible_after_edge");
        bus.writeEnableA = 1'b0;
        #1;

        // Drain the scoreboard with a bounded wait.
        for (int t = 0; t < 10 && exp_q.size() > 0; t++) begin
            ->sample_ev;
            #1;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d pending, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
